// File: rtl/mmu_tu.sv
// MIPS32 address-translation unit: fully associative joint TLB, NUM_PORTS registered lookup
// ports, CP0 TLBP/TLBR/TLBWI/TLBWR sequencer and the Random register.
module mmu_tu #(
  parameter int unsigned TLB_ENTRIES = 16,
  parameter int unsigned NUM_PORTS   = 2,
  parameter int unsigned ASID_WIDTH  = 8,
  localparam int unsigned IW         = $clog2(TLB_ENTRIES)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      k0_uncached,
  input  logic [ASID_WIDTH-1:0]     asid,
  input  logic [NUM_PORTS-1:0]      req_valid,
  input  logic [32*NUM_PORTS-1:0]   req_vaddr,
  input  logic [NUM_PORTS-1:0]      req_store,
  output logic [NUM_PORTS-1:0]      resp_valid,
  output logic [32*NUM_PORTS-1:0]   resp_paddr,
  output logic [NUM_PORTS-1:0]      resp_uncached,
  output logic [2*NUM_PORTS-1:0]    resp_exc,
  input  logic                      op_valid,
  input  logic [1:0]                op_code,
  output logic                      op_ready,
  input  logic [IW-1:0]             op_index,
  input  logic [31:0]               op_entryhi,
  input  logic [31:0]               op_entrylo0,
  input  logic [31:0]               op_entrylo1,
  input  logic [IW-1:0]             wired,
  input  logic                      wired_we,
  output logic                      op_done,
  output logic                      op_probe_fail,
  output logic [IW-1:0]             op_index_out,
  output logic [31:0]               op_entryhi_out,
  output logic [31:0]               op_entrylo0_out,
  output logic [31:0]               op_entrylo1_out,
  output logic [IW-1:0]             random
);

  localparam logic StIdle = 1'b0;
  localparam logic StBusy = 1'b1;

  localparam logic [1:0] OpTlbp  = 2'd0;
  localparam logic [1:0] OpTlbr  = 2'd1;

  localparam logic [IW-1:0] RandMax = IW'(TLB_ENTRIES - 1);

  // Entry storage; lo halves hold {PFN[24:5], C[4:2], D[1], V[0]}.
  logic [TLB_ENTRIES-1:0] present_q;
  logic [TLB_ENTRIES-1:0] g_q;
  logic [18:0]            vpn2_q [TLB_ENTRIES];
  logic [ASID_WIDTH-1:0]  asid_q [TLB_ENTRIES];
  logic [24:0]            lo0_q  [TLB_ENTRIES];
  logic [24:0]            lo1_q  [TLB_ENTRIES];

  logic                   state_q;
  logic [1:0]             code_q;
  logic [IW-1:0]          idx_q;
  logic [IW-1:0]          rnd_q;
  logic [31:0]            hi_q;
  logic [31:0]            elo0_q;
  logic [31:0]            elo1_q;
  logic [IW-1:0]          random_q;

  logic                   done_q;
  logic                   probe_fail_q;
  logic [IW-1:0]          index_out_q;
  logic [31:0]            hi_out_q;
  logic [31:0]            lo0_out_q;
  logic [31:0]            lo1_out_q;

  logic [NUM_PORTS-1:0]    valid_q;
  logic [32*NUM_PORTS-1:0] paddr_q;
  logic [NUM_PORTS-1:0]    unc_q;
  logic [2*NUM_PORTS-1:0]  exc_q;

  logic [32*NUM_PORTS-1:0] paddr_d;
  logic [NUM_PORTS-1:0]    unc_d;
  logic [2*NUM_PORTS-1:0]  exc_d;
  logic [31:0]             va     [NUM_PORTS];
  logic [24:0]             sel_lo [NUM_PORTS];
  logic [NUM_PORTS-1:0]    hit;

  logic                    accept;
  logic                    exec;
  logic                    wr_en;
  logic [IW-1:0]           wr_idx;
  logic                    probe_hit;
  logic [IW-1:0]           probe_idx;
  logic [31:0]             rd_hi;
  logic [31:0]             rd_lo0;
  logic [31:0]             rd_lo1;

  assign accept = (state_q == StIdle) && op_valid;
  assign exec   = (state_q == StBusy);
  assign wr_en  = exec && code_q[1];
  assign wr_idx = code_q[0] ? rnd_q : idx_q;

  // Lookup; iterating downward lets the lowest matching index win.
  always_comb begin
    paddr_d = '0;
    unc_d   = '0;
    exc_d   = '0;
    hit     = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      va[p]     = req_vaddr[32*p +: 32];
      sel_lo[p] = '0;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
        if (present_q[i] && vpn2_q[i] == va[p][31:13] && (g_q[i] || asid_q[i] == asid)) begin
          hit[p]    = 1'b1;
          sel_lo[p] = va[p][12] ? lo1_q[i] : lo0_q[i];
        end
      end
      if (va[p][31:30] == 2'b10) begin
        paddr_d[32*p +: 32] = {3'b000, va[p][28:0]};
        unc_d[p]            = va[p][29] | k0_uncached;
      end else if (!hit[p]) begin
        exc_d[2*p +: 2] = 2'd1;
      end else if (!sel_lo[p][0]) begin
        exc_d[2*p +: 2] = 2'd2;
      end else if (req_store[p] && !sel_lo[p][1]) begin
        exc_d[2*p +: 2] = 2'd3;
      end else begin
        paddr_d[32*p +: 32] = {sel_lo[p][24:5], va[p][11:0]};
        unc_d[p]            = (sel_lo[p][4:2] != 3'd3);
      end
    end
  end

  always_comb begin
    probe_hit = 1'b0;
    probe_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (present_q[i] && vpn2_q[i] == hi_q[31:13] &&
          (g_q[i] || asid_q[i] == hi_q[ASID_WIDTH-1:0])) begin
        probe_hit = 1'b1;
        probe_idx = i[IW-1:0];
      end
    end
  end

  always_comb begin
    rd_hi  = '0;
    rd_lo0 = '0;
    rd_lo1 = '0;
    if (present_q[idx_q]) begin
      rd_hi[31:13]           = vpn2_q[idx_q];
      rd_hi[ASID_WIDTH-1:0]  = asid_q[idx_q];
      rd_lo0                 = {6'b0, lo0_q[idx_q], g_q[idx_q]};
      rd_lo1                 = {6'b0, lo1_q[idx_q], g_q[idx_q]};
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      paddr_q <= '0;
      unc_q   <= '0;
      exc_q   <= '0;
    end else begin
      valid_q <= req_valid;
      paddr_q <= paddr_d;
      unc_q   <= unc_d;
      exc_q   <= exc_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      present_q <= '0;
      g_q       <= '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        vpn2_q[i] <= '0;
        asid_q[i] <= '0;
        lo0_q[i]  <= '0;
        lo1_q[i]  <= '0;
      end
    end else if (wr_en) begin
      present_q[wr_idx] <= 1'b1;
      g_q[wr_idx]       <= elo0_q[0] & elo1_q[0];
      vpn2_q[wr_idx]    <= hi_q[31:13];
      asid_q[wr_idx]    <= hi_q[ASID_WIDTH-1:0];
      lo0_q[wr_idx]     <= elo0_q[25:1];
      lo1_q[wr_idx]     <= elo1_q[25:1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      code_q       <= '0;
      idx_q        <= '0;
      rnd_q        <= '0;
      hi_q         <= '0;
      elo0_q       <= '0;
      elo1_q       <= '0;
      done_q       <= 1'b0;
      probe_fail_q <= 1'b0;
      index_out_q  <= '0;
      hi_out_q     <= '0;
      lo0_out_q    <= '0;
      lo1_out_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= StBusy;
        code_q  <= op_code;
        idx_q   <= op_index;
        rnd_q   <= random_q;
        hi_q    <= op_entryhi;
        elo0_q  <= op_entrylo0;
        elo1_q  <= op_entrylo1;
      end else if (exec) begin
        state_q <= StIdle;
        done_q  <= 1'b1;
        if (code_q == OpTlbp) begin
          probe_fail_q <= !probe_hit;
          index_out_q  <= probe_idx;
        end else if (code_q == OpTlbr) begin
          hi_out_q  <= rd_hi;
          lo0_out_q <= rd_lo0;
          lo1_out_q <= rd_lo1;
        end
      end
    end
  end

  // An IW-bit Wired can never exceed TLB_ENTRIES-1, so only the wrap compare is needed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      random_q <= RandMax;
    end else if (wired_we || random_q == wired) begin
      random_q <= RandMax;
    end else begin
      random_q <= random_q - 1'b1;
    end
  end

  assign op_ready        = (state_q == StIdle);
  assign op_done         = done_q;
  assign op_probe_fail   = probe_fail_q;
  assign op_index_out    = index_out_q;
  assign op_entryhi_out  = hi_out_q;
  assign op_entrylo0_out = lo0_out_q;
  assign op_entrylo1_out = lo1_out_q;
  assign random          = random_q;
  assign resp_valid      = valid_q;
  assign resp_paddr      = paddr_q;
  assign resp_uncached   = unc_q;
  assign resp_exc        = exc_q;

endmodule

// File: tb/tb_mmu_tu.sv
// Directed bench for mmu_tu: segment bypass, TLB lookups, CP0 TLB ops, Random and reset abort.
module tb_mmu_tu;

  localparam int IW = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        k0_uncached;
  logic [7:0]  asid;
  logic [1:0]  req_valid;
  logic [63:0] req_vaddr;
  logic [1:0]  req_store;
  logic [1:0]  resp_valid;
  logic [63:0] resp_paddr;
  logic [1:0]  resp_uncached;
  logic [3:0]  resp_exc;
  logic        op_valid;
  logic [1:0]  op_code;
  logic        op_ready;
  logic [IW-1:0] op_index;
  logic [31:0] op_entryhi;
  logic [31:0] op_entrylo0;
  logic [31:0] op_entrylo1;
  logic [IW-1:0] wired;
  logic        wired_we;
  logic        op_done;
  logic        op_probe_fail;
  logic [IW-1:0] op_index_out;
  logic [31:0] op_entryhi_out;
  logic [31:0] op_entrylo0_out;
  logic [31:0] op_entrylo1_out;
  logic [IW-1:0] random;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mmu_tu dut (
    .clk(clk), .resetn(resetn), .k0_uncached(k0_uncached), .asid(asid),
    .req_valid(req_valid), .req_vaddr(req_vaddr), .req_store(req_store),
    .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_uncached(resp_uncached),
    .resp_exc(resp_exc), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .op_index(op_index), .op_entryhi(op_entryhi), .op_entrylo0(op_entrylo0),
    .op_entrylo1(op_entrylo1), .wired(wired), .wired_we(wired_we), .op_done(op_done),
    .op_probe_fail(op_probe_fail), .op_index_out(op_index_out),
    .op_entryhi_out(op_entryhi_out), .op_entrylo0_out(op_entrylo0_out),
    .op_entrylo1_out(op_entrylo1_out), .random(random)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called and returns at a negedge; drives one op and checks its two-cycle handshake.
  task automatic do_op(input logic [1:0] code, input logic [IW-1:0] idx,
                       input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
    check("op_ready_idle", op_ready, 1);
    op_valid = 1'b1; op_code = code; op_index = idx;
    op_entryhi = hi; op_entrylo0 = lo0; op_entrylo1 = lo1;
    @(posedge clk); @(negedge clk);
    op_valid = 1'b0;
    check("op_ready_busy", op_ready, 0);
    check("op_done_busy", op_done, 0);
    @(posedge clk); @(negedge clk);
    check("op_done_pulse", op_done, 1);
  endtask

  // exp_unc < 0 skips the cacheability check (don't-care on exceptions).
  task automatic lookup(input string tag, input int port, input logic [31:0] va,
                        input logic st, input logic [31:0] exp_pa, input int exp_unc,
                        input logic [1:0] exp_exc);
    req_valid = '0; req_store = '0;
    req_valid[port] = 1'b1;
    req_store[port] = st;
    req_vaddr[32*port +: 32] = va;
    @(posedge clk); @(negedge clk);
    req_valid = '0;
    check({tag, "_valid"}, resp_valid[port], 1);
    check({tag, "_paddr"}, resp_paddr[32*port +: 32], exp_pa);
    check({tag, "_exc"}, resp_exc[2*port +: 2], exp_exc);
    if (exp_unc >= 0) check({tag, "_unc"}, resp_uncached[port], exp_unc[0]);
  endtask

  initial begin
    int n;
    resetn = 1'b0; k0_uncached = 1'b0; asid = 8'd5;
    req_valid = '0; req_vaddr = '0; req_store = '0;
    op_valid = 1'b0; op_code = '0; op_index = '0;
    op_entryhi = '0; op_entrylo0 = '0; op_entrylo1 = '0;
    wired = '0; wired_we = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_exc", resp_exc, 0);
    check("rst_resp_paddr", resp_paddr[31:0], 0);
    check("rst_op_ready", op_ready, 1);
    check("rst_op_done", op_done, 0);
    check("rst_probe_fail", op_probe_fail, 0);
    check("rst_random", random, 15);
    resetn = 1'b1;
    @(negedge clk); check("random_1", random, 14);
    @(negedge clk); check("random_2", random, 13);

    lookup("kseg1", 0, 32'hBFC00000, 1'b0, 32'h1FC00000, 1, 2'd0);
    lookup("kseg0", 1, 32'h80001000, 1'b0, 32'h00001000, 0, 2'd0);
    k0_uncached = 1'b1;
    lookup("kseg0_unc", 1, 32'h80001000, 1'b0, 32'h00001000, 1, 2'd0);
    k0_uncached = 1'b0;

    do_op(2'd2, 4'd3, 32'h00402005, 32'h0048D15A, 32'h0002AF10);
    lookup("tlb_load", 0, 32'h00402abc, 1'b0, 32'h12345abc, 0, 2'd0);
    lookup("tlb_store", 1, 32'h00402abc, 1'b1, 32'h0, -1, 2'd3);
    lookup("tlb_inval", 1, 32'h00403000, 1'b0, 32'h0, -1, 2'd2);
    asid = 8'd6;
    lookup("tlb_asid", 0, 32'h00402abc, 1'b0, 32'h0, -1, 2'd1);
    asid = 8'd5;

    do_op(2'd0, 4'd0, 32'h00402005, 32'h0, 32'h0);
    check("tlbp_hit_fail", op_probe_fail, 0);
    check("tlbp_hit_idx", op_index_out, 3);
    do_op(2'd0, 4'd0, 32'h00800005, 32'h0, 32'h0);
    check("tlbp_miss_fail", op_probe_fail, 1);
    check("tlbp_miss_idx", op_index_out, 0);

    do_op(2'd1, 4'd3, 32'h0, 32'h0, 32'h0);
    check("tlbr_hi", op_entryhi_out, 32'h00402005);
    check("tlbr_lo0", op_entrylo0_out, 32'h0048D15A);
    check("tlbr_lo1", op_entrylo1_out, 32'h0002AF10);
    do_op(2'd1, 4'd7, 32'h0, 32'h0, 32'h0);
    check("tlbr_empty_hi", op_entryhi_out, 0);
    check("tlbr_empty_lo0", op_entrylo0_out, 0);
    check("tlbr_empty_lo1", op_entrylo1_out, 0);

    // Lookup sampled on the write edge sees old contents; the next one hits (global entry).
    op_valid = 1'b1; op_code = 2'd2; op_index = 4'd5;
    op_entryhi = 32'h00600007; op_entrylo0 = 32'h0001DDD7; op_entrylo1 = 32'h00000001;
    @(posedge clk); @(negedge clk);
    op_valid = 1'b0; asid = 8'd9;
    req_valid = 2'b01; req_store = 2'b01; req_vaddr[31:0] = 32'h00600123;
    @(posedge clk); @(negedge clk);
    check("race_old_exc", resp_exc[1:0], 2'd1);
    check("race_done", op_done, 1);
    @(posedge clk); @(negedge clk);
    req_valid = '0; req_store = '0;
    check("race_new_exc", resp_exc[1:0], 2'd0);
    check("race_new_paddr", resp_paddr[31:0], 32'h00777123);
    check("race_new_unc", resp_uncached[0], 1);
    asid = 8'd5;

    wired = 4'd4; wired_we = 1'b1;
    @(posedge clk); @(negedge clk);
    wired_we = 1'b0;
    check("wired_reload", random, 15);
    repeat (11) @(negedge clk);
    check("random_at_wired", random, 4);
    @(negedge clk);
    check("random_wrap", random, 15);

    n = 0;
    while (random != 4'd9 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("random_reach_9", random, 9);
    do_op(2'd3, 4'd0, 32'h00C00005, 32'h00000042, 32'h0);
    do_op(2'd1, 4'd9, 32'h0, 32'h0, 32'h0);
    check("tlbwr_hi", op_entryhi_out, 32'h00C00005);
    check("tlbwr_lo0", op_entrylo0_out, 32'h00000042);

    // Reset while BUSY aborts the write and suppresses op_done.
    op_valid = 1'b1; op_code = 2'd2; op_index = 4'd6;
    op_entryhi = 32'h00A00005; op_entrylo0 = 32'h00000042; op_entrylo1 = 32'h0;
    @(posedge clk); @(negedge clk);
    op_valid = 1'b0;
    check("abort_busy", op_ready, 0);
    resetn = 1'b0;
    #1;
    check("abort_ready", op_ready, 1);
    @(negedge clk);
    resetn = 1'b1;
    check("abort_done_0", op_done, 0);
    @(negedge clk);
    check("abort_done_1", op_done, 0);
    lookup("abort_lookup", 0, 32'h00A00000, 1'b0, 32'h0, -1, 2'd1);
    do_op(2'd1, 4'd6, 32'h0, 32'h0, 32'h0);
    check("abort_tlbr_hi", op_entryhi_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mmu_tu.md
# mmu_tu

Parametrised MIPS32 address-translation unit with an N-entry, fully associative joint TLB, serving NUM_PORTS lookup ports (port 0 = fetch, port 1 = data by default) with one registered cycle of latency. Kseg0/kseg1 addresses bypass the TLB with direct mapping. Mapped addresses are checked against the TLB and return PFN, cacheability and a TLB exception code. A small FSM executes the CP0 TLB instructions TLBP, TLBR, TLBWI and TLBWR, and the unit owns the Random counter.

## Interface
- TLB_ENTRIES, 16: number of TLB entries (power of two, 4..64); IW = log2(TLB_ENTRIES)
- NUM_PORTS, 2: independent lookup ports
- ASID_WIDTH, 8: ASID width
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- k0_uncached  in  1  Config.K0 != 3
- asid  in  ASID_WIDTH  current EntryHi.ASID
- req_valid  in  NUM_PORTS  lookup request, one bit per port
- req_vaddr  in  32*NUM_PORTS  virtual address, port p at [32p+31:32p]
- req_store  in  NUM_PORTS  access is a store
- resp_valid  out  NUM_PORTS  registered req_valid
- resp_paddr  out  32*NUM_PORTS  physical address; 0 when resp_exc != 0
- resp_uncached  out  NUM_PORTS  access is uncached
- resp_exc  out  2*NUM_PORTS  0 none, 1 refill, 2 invalid, 3 modified
- op_valid  in  1  TLB op request
- op_code  in  2  0 TLBP, 1 TLBR, 2 TLBWI, 3 TLBWR
- op_ready  out  1  FSM idle, op accepted when op_valid && op_ready
- op_index  in  IW  CP0 Index
- op_entryhi  in  32  {VPN2[31:13], 5'b0, ASID}
- op_entrylo0, op_entrylo1  in  32  {6'b0, PFN[25:6], C[5:3], D[2], V[1], G[0]}
- wired  in  IW  CP0 Wired
- wired_we  in  1  pulse: Wired was written
- op_done  out  1  one-cycle completion pulse
- op_probe_fail  out  1  TLBP miss (Index.P)
- op_index_out  out  IW  TLBP hit index
- op_entryhi_out, op_entrylo0_out, op_entrylo1_out  out  32  TLBR result
- random  out  IW  CP0 Random

## Operation
- Segment: mapped iff vaddr[31]==0 or vaddr[31:30]==2'b11.
- Unmapped: paddr = {3'b0, vaddr[28:0]}. Kseg1 (101) is always uncached. Kseg0 is uncached iff k0_uncached. exc = 0.
- Entry state: present, VPN2[18:0], ASID, G, and two lo halves {PFN[19:0], C, D, V}.
- Match: present && VPN2 == vaddr[31:13] && (G || ASID == asid). Multiple hits are resolved by the lowest index.
- Lo half select: vaddr[12] (1 = odd).
- Exception priority: no match → refill; V==0 → invalid; req_store && D==0 → modified.
- Otherwise paddr = {PFN, vaddr[11:0]} and uncached = (C != 3).
- G written = entrylo0.G & entrylo1.G. Writing any entry sets its present bit.
- FSM has two states: IDLE and BUSY.
  - IDLE: op_ready=1. On accept, latch op_code, index, entryhi, entrylo0/1 and random → BUSY.
  - BUSY: op_ready=0. The op executes at the BUSY→IDLE edge, and op_done and the result registers update on that same edge.
- TLBP: op_probe_fail = no match using the latched entryhi; op_index_out = hit index, or 0 on miss.
- TLBR: read entry[index] into the *_out registers; G is replicated into both lo halves. A non-present entry reads as all zero.
- TLBWI writes entry[index]. TLBWR writes entry[random latched at accept].
- Random:
  - Reset and wired_we load TLB_ENTRIES-1.
  - Otherwise it decrements every cycle, and when random == wired the next value is TLB_ENTRIES-1.
  - If wired > TLB_ENTRIES-1, random holds at TLB_ENTRIES-1.
- Reset values: all entries non-present; resp_valid/resp_exc/resp_uncached/resp_paddr = 0; op_done = 0; all *_out and op_probe_fail = 0; FSM in IDLE (op_ready=1); random = TLB_ENTRIES-1.

## Timing
- Lookup: request in cycle t → response registered at the end of t, visible in t+1. There is no backpressure, and back-to-back requests are allowed on every port.
- A write executing at edge e is seen by lookups sampled in the cycle after e. A lookup sampled in the same cycle as the write sees the old contents.
- Op latency: accept at edge a, BUSY during [a, a+1), op_done high during [a+1, a+2).
- A new op may be accepted in the op_done cycle.
- op_valid while BUSY is ignored; the requester holds op_valid until it sees op_ready.
- Simultaneous wired_we and TLBWR accept: TLBWR uses the random value before the reload.
- Asynchronous reset mid-op: the op is aborted, no entry is written and op_done stays 0.

## Test plan
- Unmapped: port 0 vaddr 0xBFC00000 → paddr 0x1FC00000, uncached=1. Port 1 vaddr 0x80001000 with k0_uncached=0 → paddr 0x00001000, uncached=0, exc=0, one cycle later.
- TLBWI index 3: entryhi 0x00402005, lo0 PFN 0x12345 C=3 V=1 D=0, lo1 V=0. Then:
  - load at 0x00402abc, asid 5 → paddr 0x12345abc, exc 0;
  - store at the same address → exc 3;
  - load at 0x00403000 → exc 2;
  - asid 6 → exc 1.
- TLBP with the same entryhi → op_done 2 cycles after accept, probe_fail 0, index 3. Entryhi 0x00800005 → probe_fail 1.
- TLBR index 3 → entryhi_out 0x00402005 and the lo values as written, with G=0. TLBR of an unwritten index → all zero.
- Random: after reset it reads 15,14,…; with wired=4 it wraps 4→15. A wired_we pulse reloads 15. A TLBWR accepted while random=9 writes entry 9.
- Write/lookup race: a lookup sampled in the cycle of the TLBWI edge misses (refill), and the next cycle hits. Reset asserted during BUSY → no write and no op_done.
